// File: rtl/n64_bit_encoder.sv
// n64_bit_encoder: serialises one N64 one-wire command frame.
// Each data bit becomes a 4-slot pulse-width code on line_oe (1 = pull line low).
// Data comes from an external rotating shift register: din is its dout and
// bit_req drives its enable.
// Optional macro N64_STOP_BIT_EN: appends the console stop bit (1 slot low, 2 slots high).
// With the macro undefined, done follows the last data bit directly.
module n64_bit_encoder #(
   parameter int QDIV  = 12,  // clk cycles per 1 us slot, >= 2
   parameter int NBITS = 8    // data bits per frame, 1..64
) (
   input  logic clk,
   input  logic rstn,
   input  logic start,
   input  logic din,
   output logic bit_req,
   output logic line_oe,
   output logic busy,
   output logic done
);

   localparam int TW = $clog2(QDIV);
   localparam int CW = $clog2(NBITS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
`ifdef N64_STOP_BIT_EN
   localparam logic [1:0] S_STOP = 2'd2;
`endif

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    slot_q, slot_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic          cur_bit_q, cur_bit_d;
   logic          line_oe_d, bit_req_d, busy_d, done_d;
   logic          slot_tick, last_bit;

   assign slot_tick = (timer_q == TW'(QDIV - 1));
   assign last_bit  = (bit_cnt_q == CW'(NBITS - 1));

   // Next-state: slot timer, slot/bit counters, FSM and bit capture
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      slot_d    = slot_q;
      bit_cnt_d = bit_cnt_q;
      cur_bit_d = cur_bit_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_DATA;
               timer_d   = '0;
               slot_d    = 2'd0;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            // Shift register output is valid one cycle after bit_req: first cycle of slot0
            if (slot_q == 2'd0 && timer_q == '0) begin
               cur_bit_d = din;
            end
            if (slot_tick) begin
               timer_d = '0;
               slot_d  = slot_q + 2'd1;
               if (slot_q == 2'd3) begin
                  if (last_bit) begin
                     bit_cnt_d = '0;
`ifdef N64_STOP_BIT_EN
                     state_d = S_STOP;
`else
                     state_d = S_IDLE;
                     done_d  = 1'b1;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`ifdef N64_STOP_BIT_EN
         S_STOP: begin
            if (slot_tick) begin
               timer_d = '0;
               if (slot_q == 2'd2) begin
                  slot_d  = 2'd0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  slot_d = slot_q + 2'd1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from next state so every output is a plain register
   always_comb begin
      line_oe_d = 1'b0;
      busy_d    = (state_d != S_IDLE);
      bit_req_d = (state_d == S_DATA) && (slot_d == 2'd3) && (timer_d == TW'(QDIV - 1));
      case (state_d)
         S_DATA: begin
            case (slot_d)
               2'd0:    line_oe_d = 1'b1;
               2'd1:    line_oe_d = ~cur_bit_d;
               2'd2:    line_oe_d = ~cur_bit_d;
               default: line_oe_d = 1'b0;
            endcase
         end
`ifdef N64_STOP_BIT_EN
         S_STOP: begin
            line_oe_d = (slot_d == 2'd0);
         end
`endif
         default: begin
            line_oe_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset releases the line immediately
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         slot_q    <= 2'd0;
         bit_cnt_q <= '0;
         cur_bit_q <= 1'b0;
         line_oe   <= 1'b0;
         bit_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         slot_q    <= slot_d;
         bit_cnt_q <= bit_cnt_d;
         cur_bit_q <= cur_bit_d;
         line_oe   <= line_oe_d;
         bit_req   <= bit_req_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_n64_bit_encoder.sv
// Bench for n64_bit_encoder (QDIV=2, NBITS=8); follows N64_STOP_BIT_EN when defined.
module tb_n64_bit_encoder;

   localparam int QDIV  = 2;
   localparam int NBITS = 8;
`ifdef N64_STOP_BIT_EN
   localparam int STOPC = 6;
   localparam logic [5:0] TAIL = 6'b110000;
`else
   localparam int STOPC = 0;
   localparam logic [5:0] TAIL = 6'b000000;
`endif
   localparam int LEN = NBITS * 4 * QDIV + STOPC;
   localparam int WIN = 80;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic din = 1'b0;
   logic bit_req, line_oe, busy, done;

   int checks = 0;
   int failures = 0;

   n64_bit_encoder #(.QDIV(QDIV), .NBITS(NBITS)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
      .din     (din),
      .bit_req (bit_req),
      .line_oe (line_oe),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         ones;  // line_oe high cycles over the 64 data cycles
      bit         inj;   // extra starts at cycles 10 and 40
   } vec_t;

   // Send one frame of data (MSB-first from a modelled rotating register) and check it
   task automatic run_frame(input logic [7:0] data, input int ones, input bit inj);
      logic lo [WIN];
      logic br [WIN];
      logic bs [WIN];
      logic dn [WIN];
      int idx, blen, sum, err, nreq, ndone;
      logic [7:0] dec;
      logic [5:0] tail;
      bit run;
      idx = 0;
      din = data[7];
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < WIN; k++) begin
         lo[k] = line_oe;
         br[k] = bit_req;
         bs[k] = busy;
         dn[k] = done;
         start = inj && (k == 10 || k == 40);
         if (bit_req) begin
            idx++;
            din = data[7 - (idx % 8)];
         end
         @(negedge clk);
      end
      start = 1'b0;
      blen = 0;
      run = 1'b1;
      for (int k = 0; k < WIN; k++) begin
         if (run && bs[k] === 1'b1) blen++;
         else run = 1'b0;
      end
      chk("busy_len", blen, LEN);
      sum = 0;
      for (int k = 0; k < 64; k++) if (lo[k] === 1'b1) sum++;
      chk("data_ones", sum, ones);
      err = 0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            logic e;
            if (j < 2) e = 1'b1;
            else if (j < 6) e = ~data[7 - i];
            else e = 1'b0;
            if (lo[8 * i + j] !== e) err++;
         end
         dec[7 - i] = ~lo[8 * i + 3];
      end
      chk("bit_shape_errs", err, 0);
      chk("decoded_byte", dec, data);
      nreq = 0;
      err = 0;
      for (int k = 0; k < WIN; k++) begin
         if (br[k] === 1'b1) nreq++;
         if (br[k] !== ((k % 8 == 7) && (k < 64))) err++;
      end
      chk("bit_req_count", nreq, 8);
      chk("bit_req_pos_errs", err, 0);
      for (int j = 0; j < 6; j++) tail[5 - j] = lo[64 + j];
      chk("tail_line_oe", tail, TAIL);
      ndone = 0;
      for (int k = 0; k < WIN; k++) if (dn[k] === 1'b1) ndone++;
      chk("done_count", ndone, 1);
      chk("done_at_end", dn[LEN], 1'b1);
      err = 0;
      for (int k = LEN; k < WIN; k++) if (lo[k] !== 1'b0) err++;
      chk("released_after", err, 0);
   endtask

   vec_t tbl [5];
   int n;

   initial begin
      tbl[0] = '{data: 8'h00, ones: 48, inj: 1'b0};
      tbl[1] = '{data: 8'h01, ones: 44, inj: 1'b0};
      tbl[2] = '{data: 8'hFF, ones: 16, inj: 1'b0};
      tbl[3] = '{data: 8'hA5, ones: 32, inj: 1'b0};
      tbl[4] = '{data: 8'h3C, ones: 32, inj: 1'b1};

      // Reset held with start and din high: everything stays quiet
      start = 1'b1;
      din = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("reset_outputs", {line_oe, bit_req, busy, done}, 4'b0000);
      end
      start = 1'b0;
      din = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_outputs", {line_oe, bit_req, busy, done}, 4'b0000);

      for (int t = 0; t < 5; t++) begin
         run_frame(tbl[t].data, tbl[t].ones, tbl[t].inj);
      end

      // Reset at cycle 20 of a frame: line released at once, no done
      din = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 20; k++) @(negedge clk);
      chk("pre_reset_busy", busy, 1'b1);
      rstn = 1'b0;
      #1;
      chk("midreset_outputs", {line_oe, bit_req, busy, done}, 4'b0000);
      n = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || line_oe !== 1'b0) n++;
      end
      chk("midreset_quiet_errs", n, 0);
      rstn = 1'b1;
      @(negedge clk);
      run_frame(8'h00, 48, 1'b0);

      // Back-to-back: start on the done cycle is accepted
      din = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < WIN) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_cycle", n, LEN);
      chk("b2b_done_state", {line_oe, busy}, 2'b00);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("b2b_restart", {busy, line_oe}, 2'b11);
      n = 0;
      while (busy === 1'b1 && n < WIN) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_second_len", n, LEN);
      chk("b2b_second_done", done, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
